// File: rtl/video_switch_sequencer.sv
// ============================================================================
// video_switch_sequencer: blanks, applies, settles and re-locks video on every
// input reconfiguration (monitor config word or rear-panel sync toggle).
// Revision: 1.0
// ============================================================================
`default_nettype none

module video_switch_sequencer #(
  parameter int unsigned SETTLE_CYCLES       = 50000,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 5000000,
  parameter int unsigned STABLE_CYCLES       = 1000000,
  parameter logic [2:0]  RESET_CFG           = 3'b000,
  parameter int unsigned CNT_W               = 23
) (
  input  logic       clk_50mhz_in,
  input  logic       reset_x,
  input  logic       cfg_req_valid,
  input  logic [2:0] cfg_req,
  output logic       cfg_req_ready,
  input  logic       btn_toggle,
  input  logic       signal_present,
  input  logic [7:0] video_format,
  output logic [2:0] cfg_out,
  output logic       video_oe_x,
  output logic       video_reset,
  output logic       busy,
  output logic       lock_fail,
  output logic [7:0] locked_format
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BLANK     = 3'd1,
    S_APPLY     = 3'd2,
    S_SETTLE    = 3'd3,
    S_WAIT_LOCK = 3'd4,
    S_STABLE    = 3'd5
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;       // settle, then stable countdown
  logic [CNT_W-1:0] tmo_q;       // lock-search timeout
  logic [2:0]       cfg_out_q;
  logic [2:0]       next_cfg_q;
  logic             oe_x_q;
  logic             vreset_q;
  logic             lock_fail_q;
  logic [7:0]       locked_q;
  logic [7:0]       cap_q;
  logic             btn_pending_q;
  logic             no_lock_q;
  logic             sig_q;

  logic       w_lock_seen;
  logic       w_cnt_end;
  logic       w_tmo_end;
  logic       w_idle_req;
  logic [2:0] w_idle_cfg;
  logic       w_btn_served;

  assign w_lock_seen  = signal_present && (video_format != 8'h00);
  assign w_cnt_end    = (cnt_q <= CNT_W'(1));
  assign w_tmo_end    = (tmo_q <= CNT_W'(1));
  assign w_idle_req   = cfg_req_valid || btn_pending_q;
  assign w_idle_cfg   = cfg_req_valid ? cfg_req : {cfg_out_q[2:1], ~cfg_out_q[0]};
  // The button is only consumed when the monitor is not also asking.
  assign w_btn_served = (state_q == S_IDLE) && !cfg_req_valid && btn_pending_q;

  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      state_q       <= S_SETTLE;
      cnt_q         <= CNT_W'(SETTLE_CYCLES);
      tmo_q         <= '0;
      cfg_out_q     <= RESET_CFG;
      next_cfg_q    <= RESET_CFG;
      oe_x_q        <= 1'b1;
      vreset_q      <= 1'b1;
      lock_fail_q   <= 1'b0;
      locked_q      <= 8'h00;
      cap_q         <= 8'h00;
      btn_pending_q <= 1'b0;
      no_lock_q     <= 1'b0;
      sig_q         <= 1'b0;
    end else begin
      lock_fail_q <= 1'b0;
      sig_q       <= signal_present;

      if (w_btn_served)
        btn_pending_q <= 1'b0;
      else if (btn_toggle)
        btn_pending_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (w_idle_req && (w_idle_cfg != cfg_out_q)) begin
            next_cfg_q <= w_idle_cfg;
            oe_x_q     <= 1'b1;
            state_q    <= S_BLANK;
          end else if (!no_lock_q && !signal_present) begin
            oe_x_q  <= 1'b1;
            tmo_q   <= CNT_W'(LOCK_TIMEOUT_CYCLES);
            state_q <= S_WAIT_LOCK;
          end else if (no_lock_q && signal_present && !sig_q) begin
            tmo_q   <= CNT_W'(LOCK_TIMEOUT_CYCLES);
            state_q <= S_WAIT_LOCK;
          end
        end
        S_BLANK: begin
          oe_x_q  <= 1'b1;
          state_q <= S_APPLY;
        end
        S_APPLY: begin
          cfg_out_q <= next_cfg_q;
          vreset_q  <= 1'b1;
          cnt_q     <= CNT_W'(SETTLE_CYCLES);
          state_q   <= S_SETTLE;
        end
        S_SETTLE: begin
          if (w_cnt_end) begin
            cnt_q    <= '0;
            vreset_q <= 1'b0;
            tmo_q    <= CNT_W'(LOCK_TIMEOUT_CYCLES);
            state_q  <= S_WAIT_LOCK;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (tmo_q != '0) tmo_q <= tmo_q - CNT_W'(1);
          if (w_lock_seen) begin
            cap_q   <= video_format;
            cnt_q   <= CNT_W'(STABLE_CYCLES);
            state_q <= S_STABLE;
          end else if (w_tmo_end) begin
            lock_fail_q <= 1'b1;
            oe_x_q      <= 1'b1;
            no_lock_q   <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_STABLE: begin
          if (tmo_q != '0) tmo_q <= tmo_q - CNT_W'(1);
          if (!signal_present || (video_format != cap_q)) begin
            state_q <= S_WAIT_LOCK;
          end else if (w_cnt_end) begin
            locked_q  <= cap_q;
            oe_x_q    <= 1'b0;
            no_lock_q <= 1'b0;
            state_q   <= S_IDLE;
          end else if (w_tmo_end) begin
            lock_fail_q <= 1'b1;
            oe_x_q      <= 1'b1;
            no_lock_q   <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_req_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign cfg_out       = cfg_out_q;
  assign video_oe_x    = oe_x_q;
  assign video_reset   = vreset_q;
  assign lock_fail     = lock_fail_q;
  assign locked_format = locked_q;

endmodule

`default_nettype wire
